memory_module: RTL and testbench

MEMORY_MODULE -- requirements
Module: memory_module

---
 rtl/memory_module.sv | 107 ++++++++++
 tb/tb_memory_module.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/memory_module.sv
// Dual-bank 4x4 byte matrix store: control selects which bank is written each
// cycle and which bank drives the outputs combinationally.
module memory_module (
  input  logic       clk,
  input  logic       rst,
  input  logic       control,
  input  logic [7:0] arr_in0,
  input  logic [7:0] arr_in1,
  input  logic [7:0] arr_in2,
  input  logic [7:0] arr_in3,
  input  logic [7:0] arr_in4,
  input  logic [7:0] arr_in5,
  input  logic [7:0] arr_in6,
  input  logic [7:0] arr_in7,
  input  logic [7:0] arr_in8,
  input  logic [7:0] arr_in9,
  input  logic [7:0] arr_in10,
  input  logic [7:0] arr_in11,
  input  logic [7:0] arr_in12,
  input  logic [7:0] arr_in13,
  input  logic [7:0] arr_in14,
  input  logic [7:0] arr_in15,
  output logic [7:0] arr_out0,
  output logic [7:0] arr_out1,
  output logic [7:0] arr_out2,
  output logic [7:0] arr_out3,
  output logic [7:0] arr_out4,
  output logic [7:0] arr_out5,
  output logic [7:0] arr_out6,
  output logic [7:0] arr_out7,
  output logic [7:0] arr_out8,
  output logic [7:0] arr_out9,
  output logic [7:0] arr_out10,
  output logic [7:0] arr_out11,
  output logic [7:0] arr_out12,
  output logic [7:0] arr_out13,
  output logic [7:0] arr_out14,
  output logic [7:0] arr_out15
);

  localparam int unsigned LANES = 16;

  logic [7:0] in_lane  [LANES];
  logic [7:0] out_lane [LANES];
  logic [7:0] bank_m   [LANES];
  logic [7:0] bank_f   [LANES];

  // Gather the flat row-major ports into lane arrays.
  assign in_lane[0]  = arr_in0;
  assign in_lane[1]  = arr_in1;
  assign in_lane[2]  = arr_in2;
  assign in_lane[3]  = arr_in3;
  assign in_lane[4]  = arr_in4;
  assign in_lane[5]  = arr_in5;
  assign in_lane[6]  = arr_in6;
  assign in_lane[7]  = arr_in7;
  assign in_lane[8]  = arr_in8;
  assign in_lane[9]  = arr_in9;
  assign in_lane[10] = arr_in10;
  assign in_lane[11] = arr_in11;
  assign in_lane[12] = arr_in12;
  assign in_lane[13] = arr_in13;
  assign in_lane[14] = arr_in14;
  assign in_lane[15] = arr_in15;

  // NOTE: both banks must read zero after reset, so the storage is cleared in
  // the reset branch and therefore maps to flops, not a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
        bank_m[i] <= '0;
        bank_f[i] <= '0;
      end
    end else if (control) begin
      for (int i = 0; i < LANES; i++) bank_m[i] <= in_lane[i];
    end else begin
      for (int i = 0; i < LANES; i++) bank_f[i] <= in_lane[i];
    end
  end

  // NOTE: every lane gets a default before the select so no latch is inferred.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      out_lane[i] = bank_f[i];
      if (control) out_lane[i] = bank_m[i];
    end
  end

  assign arr_out0  = out_lane[0];
  assign arr_out1  = out_lane[1];
  assign arr_out2  = out_lane[2];
  assign arr_out3  = out_lane[3];
  assign arr_out4  = out_lane[4];
  assign arr_out5  = out_lane[5];
  assign arr_out6  = out_lane[6];
  assign arr_out7  = out_lane[7];
  assign arr_out8  = out_lane[8];
  assign arr_out9  = out_lane[9];
  assign arr_out10 = out_lane[10];
  assign arr_out11 = out_lane[11];
  assign arr_out12 = out_lane[12];
  assign arr_out13 = out_lane[13];
  assign arr_out14 = out_lane[14];
  assign arr_out15 = out_lane[15];

endmodule

// File: tb/tb_memory_module.sv
// Scoreboard bench for memory_module: the driver pushes the expected matrix for
// each cycle, the monitor compares it against the outputs at the falling edge.
module tb_memory_module;

  logic       clk = 1'b0;
  logic       rst;
  logic       control;
  logic [7:0] din  [16];
  logic [7:0] dout [16];

  always #5 clk = ~clk;

  memory_module dut (
    .clk(clk), .rst(rst), .control(control),
    .arr_in0(din[0]),   .arr_in1(din[1]),   .arr_in2(din[2]),   .arr_in3(din[3]),
    .arr_in4(din[4]),   .arr_in5(din[5]),   .arr_in6(din[6]),   .arr_in7(din[7]),
    .arr_in8(din[8]),   .arr_in9(din[9]),   .arr_in10(din[10]), .arr_in11(din[11]),
    .arr_in12(din[12]), .arr_in13(din[13]), .arr_in14(din[14]), .arr_in15(din[15]),
    .arr_out0(dout[0]),   .arr_out1(dout[1]),   .arr_out2(dout[2]),   .arr_out3(dout[3]),
    .arr_out4(dout[4]),   .arr_out5(dout[5]),   .arr_out6(dout[6]),   .arr_out7(dout[7]),
    .arr_out8(dout[8]),   .arr_out9(dout[9]),   .arr_out10(dout[10]), .arr_out11(dout[11]),
    .arr_out12(dout[12]), .arr_out13(dout[13]), .arr_out14(dout[14]), .arr_out15(dout[15])
  );

  typedef struct {
    string        name;
    logic [127:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        errors = 0;
  int        checks = 0;

  // Reference model: two plain byte matrices.
  logic [7:0] model_m [16];
  logic [7:0] model_f [16];

  function automatic logic [127:0] pack(input logic [7:0] v [16]);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = v[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%032h expected=%032h", name, got, exp);
    end
  endtask

  // Monitor: compares whatever is on the outputs mid-cycle against the scoreboard.
  initial begin
    sb_entry_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, pack(dout), e.exp);
      end
    end
  end

  // One cycle: apply inputs, push what the outputs should show now, optionally
  // flip control just before the edge, then apply the edge to the model.
  task automatic step(input logic r, input logic c, input logic [7:0] v [16],
                      input bit flip, input string name);
    sb_entry_t e;
    rst     = r;
    control = c;
    for (int i = 0; i < 16; i++) din[i] = v[i];
    e.name = name;
    e.exp  = c ? pack(model_m) : pack(model_f);
    sb_q.push_back(e);
    @(negedge clk);
    if (flip) begin
      #2 control = ~control;
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        model_m[i] = 8'd0;
        model_f[i] = 8'd0;
      end
    end else if (control) begin
      for (int i = 0; i < 16; i++) model_m[i] = din[i];
    end else begin
      for (int i = 0; i < 16; i++) model_f[i] = din[i];
    end
    #1;
  endtask

  logic [7:0] seq_v [16];
  logic [7:0] fpat  [16];
  logic [7:0] ones  [16];
  logic [7:0] zero  [16];
  logic [7:0] sevn  [16];
  logic [7:0] rnd   [16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      seq_v[i] = 8'(i + 1);
      fpat[i]  = (i <= 8) ? 8'd240 : 8'd15;
      ones[i]  = 8'd255;
      zero[i]  = 8'd0;
      sevn[i]  = 8'd7;
      din[i]   = 8'd0;
    end
    rst     = 1'b1;
    control = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      model_m[i] = 8'd0;
      model_f[i] = 8'd0;
    end
    #1;

    // Directed sequence
    step(1'b0, 1'b1, seq_v, 1'b0, "reset_m_zero");
    step(1'b0, 1'b0, fpat,  1'b0, "reset_f_zero");
    step(1'b0, 1'b1, seq_v, 1'b0, "m_load_1_16");
    step(1'b0, 1'b0, fpat,  1'b0, "f_load_pattern");
    step(1'b1, 1'b1, seq_v, 1'b0, "rst_no_effect_midcycle");
    step(1'b0, 1'b1, seq_v, 1'b0, "rst_priority_m_zero");
    step(1'b0, 1'b0, ones,  1'b0, "rst_cleared_f");
    step(1'b0, 1'b1, zero,  1'b0, "iso_m_before");
    step(1'b0, 1'b0, zero,  1'b0, "iso_f_kept_255");
    step(1'b0, 1'b1, seq_v, 1'b0, "iso_m_zeroed");
    step(1'b0, 1'b0, ones,  1'b0, "iso_f_zeroed");
    step(1'b1, 1'b0, seq_v, 1'b0, "f_before_rst_ctl0");
    step(1'b0, 1'b1, seq_v, 1'b0, "rst_ctl0_clears_m");
    step(1'b0, 1'b1, sevn,  1'b1, "pre_flip_m");
    step(1'b0, 1'b0, sevn,  1'b0, "flip_wrote_f_7");
    step(1'b0, 1'b1, seq_v, 1'b0, "flip_m_unchanged");

    // Randomized sequence
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 3))
          0:       rnd[i] = 8'd0;
          1:       rnd[i] = 8'd255;
          default: rnd[i] = 8'($urandom);
        endcase
      end
      step(($urandom_range(0, 15) == 0), 1'($urandom), rnd,
           ($urandom_range(0, 7) == 0), "random");
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(posedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
